// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-port memory responder with fixed wait states
// Valid/ready request-response slave; storage access happens on the edge entering RESP.
module mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [DATA_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_be_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [BYTES-1:0]      r_be;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    logic                  w_idle;
    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_cur_write;
    logic [DATA_WIDTH-1:0] w_cur_addr;
    logic [DATA_WIDTH-1:0] w_cur_wdata;
    logic [BYTES-1:0]      w_cur_be;
    logic [DATA_WIDTH-1:0] w_word_idx;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_err;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle && req_valid_i;

    // With zero wait states the access coincides with acceptance, so use the live request.
    assign w_cur_write = w_idle ? req_write_i : r_write;
    assign w_cur_addr  = w_idle ? req_addr_i  : r_addr;
    assign w_cur_wdata = w_idle ? req_wdata_i : r_wdata;
    assign w_cur_be    = w_idle ? req_be_i    : r_be;

    assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                          ((r_state == S_WAIT) && (r_cnt == 4'd1));

    assign w_word_idx = {2'b00, w_cur_addr[DATA_WIDTH-1:2]};
    assign w_idx      = w_word_idx[IDX_W-1:0];
    assign w_err      = (w_cur_addr[1:0] != 2'b00) ||
                        (w_word_idx >= DATA_WIDTH'(MEM_WORDS));

    assign req_ready_o = w_idle;
    assign rsp_valid_o = (r_state == S_RESP);
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= req_write_i;
                r_addr  <= req_addr_i;
                r_wdata <= req_wdata_i;
                r_be    <= req_be_i;
            end

            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (!w_cur_write && !w_err) ? r_mem[w_idx] : '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (WAIT_CYCLES == 0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Storage is deliberately outside the reset domain; gating on rst_ni drops any store cut short by reset.
    always_ff @(posedge clk_i) begin
        if (rst_ni && w_enter_resp && w_cur_write && !w_err) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_cur_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_cur_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
// Instance a uses WAIT_CYCLES=2, instance z uses WAIT_CYCLES=0.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        a_req_valid, a_req_ready, a_req_write;
    logic [31:0] a_req_addr, a_req_wdata;
    logic [3:0]  a_req_be;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_write;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int total = 0;
    int bad   = 0;

    mem_responder #(.DATA_WIDTH(32), .MEM_WORDS(1024), .WAIT_CYCLES(2)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_write_i(a_req_write),
        .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata), .req_be_i(a_req_be),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
        .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err)
    );

    mem_responder #(.DATA_WIDTH(32), .MEM_WORDS(1024), .WAIT_CYCLES(0)) u_dut_z (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(z_req_valid), .req_ready_o(z_req_ready), .req_write_i(z_req_write),
        .req_addr_i(z_req_addr), .req_wdata_i(z_req_wdata), .req_be_i(z_req_be),
        .rsp_valid_o(z_rsp_valid), .rsp_ready_i(z_rsp_ready),
        .rsp_rdata_o(z_rsp_rdata), .rsp_err_o(z_rsp_err)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drives one request on instance a (called at a negedge), returns response and accept-to-valid latency.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] rdata, output logic err,
                         output int lat);
        int guard;
        a_req_write = wr;
        a_req_addr  = addr;
        a_req_wdata = wdata;
        a_req_be    = be;
        a_req_valid = 1'b1;
        guard = 0;
        while (!a_req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        lat = 1;
        while (!a_rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = a_rsp_rdata;
        err   = a_rsp_err;
        if (!a_rsp_valid) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: rsp_valid=%0b want 1", a_rsp_valid);
        end else if (a_rsp_ready) begin
            @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
        a_rsp_ready = 1'b1;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
        z_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got %0b want 1", a_req_ready); end
        total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got %0b want 0", a_rsp_valid); end
        total++; if (a_rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got %h want 0", a_rsp_rdata); end
        total++; if (a_rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got %0b want 0", a_rsp_err); end
        total++; if (z_req_ready !== 1'b1 || z_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL reset_z got ready=%0b valid=%0b want 1/0", z_req_ready, z_rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Request presented right at deassertion must be taken on the very next edge.
    task automatic test_first_accept();
        int lat;
        a_req_write = 1'b1; a_req_addr = 32'h0; a_req_wdata = 32'h0BADF00D; a_req_be = 4'hF;
        a_req_valid = 1'b1;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        total++; if (a_req_ready !== 1'b0) begin bad++; $display("FAIL first_accept req_ready got %0b want 0", a_req_ready); end
        lat = 1;
        while (!a_rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        total++; if (lat !== 3) begin bad++; $display("FAIL first_accept_latency got %0d want 3", lat); end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL store_latency got %0d want 3", lat); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL store_err got %0b want 0", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL store_rdata got %h want 0", rd); end
        issue(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL load_latency got %0d want 3", lat); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL load_rdata got %h want deadbeef", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL load_err got %0b want 0", er); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic er; int lat;
        issue(1'b1, 32'h10, 32'h000000AA, 4'h1, rd, er, lat);
        issue(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        total++; if (rd !== 32'hDEADBEAA) begin bad++; $display("FAIL be1_rdata got %h want deadbeaa", rd); end
        issue(1'b1, 32'h10, 32'h12345678, 4'h0, rd, er, lat);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL be0_err got %0b want 0", er); end
        issue(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        total++; if (rd !== 32'hDEADBEAA) begin bad++; $display("FAIL be0_rdata got %h want deadbeaa", rd); end
        issue(1'b1, 32'h10, 32'hCAFE0000, 4'hC, rd, er, lat);
        issue(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        total++; if (rd !== 32'hCAFEBEAA) begin bad++; $display("FAIL beC_rdata got %h want cafebeaa", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        issue(1'b0, 32'h12, 32'h0, 4'hF, rd, er, lat);
        total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL misaligned_load got err=%0b rdata=%h want 1/0", er, rd); end
        issue(1'b0, 32'h1000, 32'h0, 4'hF, rd, er, lat);
        total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL range_load got err=%0b rdata=%h want 1/0", er, rd); end
        issue(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, er, lat);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL range_store_err got %0b want 1", er); end
        issue(1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, rd, er, lat);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL misaligned_store_err got %0b want 1", er); end
        issue(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        total++; if (rd !== 32'h0BADF00D || er !== 1'b0) begin bad++; $display("FAIL word0_intact got %h err=%0b want 0badf00d/0", rd, er); end
        issue(1'b1, 32'hFFC, 32'h76543210, 4'hF, rd, er, lat);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL last_word_store_err got %0b want 0", er); end
        issue(1'b0, 32'hFFC, 32'h0, 4'h0, rd, er, lat);
        total++; if (rd !== 32'h76543210 || er !== 1'b0) begin bad++; $display("FAIL last_word_load got %h err=%0b want 76543210/0", rd, er); end
    endtask

    task automatic test_stall();
        logic [31:0] rd; logic er; int lat; int guard;
        a_rsp_ready = 1'b0;
        a_req_write = 1'b0; a_req_addr = 32'h10; a_req_be = 4'h0; a_req_valid = 1'b1;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        guard = 0;
        while (!a_rsp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
        total++; if (a_rsp_valid !== 1'b1) begin bad++; $display("FAIL stall_timeout got valid=%0b want 1", a_rsp_valid); end
        // Request presented while busy must be ignored.
        a_req_write = 1'b1; a_req_addr = 32'h10; a_req_wdata = 32'h0; a_req_be = 4'hF; a_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'hCAFEBEAA || a_req_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold[%0d] got valid=%0b rdata=%h ready=%0b want 1/cafebeaa/0",
                         i, a_rsp_valid, a_rsp_rdata, a_req_ready);
            end
        end
        @(negedge clk);
        a_rsp_ready = 1'b1;
        a_req_valid = 1'b0;
        @(posedge clk);
        #1;
        total++; if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL stall_release got ready=%0b valid=%0b want 1/0", a_req_ready, a_rsp_valid);
        end
        @(negedge clk);
        issue(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        total++; if (rd !== 32'hCAFEBEAA) begin bad++; $display("FAIL busy_req_ignored got %h want cafebeaa", rd); end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd; logic er; int lat;
        issue(1'b1, 32'h20, 32'h11111111, 4'hF, rd, er, lat);
        a_req_write = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'h22222222; a_req_be = 4'hF;
        a_req_valid = 1'b1;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        total++; if (a_req_ready !== 1'b0) begin bad++; $display("FAIL abort_in_wait got ready=%0b want 0", a_req_ready); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'h0 || a_rsp_err !== 1'b0) begin
            bad++; $display("FAIL abort_outputs got ready=%0b valid=%0b rdata=%h err=%0b want 1/0/0/0",
                            a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        total++; if (rd !== 32'h11111111) begin bad++; $display("FAIL abort_no_commit got %h want 11111111", rd); end
        total++; if (lat !== 3) begin bad++; $display("FAIL abort_latency got %0d want 3", lat); end
    endtask

    task automatic test_zero_wait();
        @(negedge clk);
        z_rsp_ready = 1'b1;
        z_req_write = 1'b1; z_req_addr = 32'h40; z_req_wdata = 32'hA5A5A5A5; z_req_be = 4'hF;
        z_req_valid = 1'b1;
        @(posedge clk);
        #1;
        total++; if (z_rsp_valid !== 1'b1 || z_req_ready !== 1'b0 || z_rsp_err !== 1'b0) begin
            bad++; $display("FAIL zw_store got valid=%0b ready=%0b err=%0b want 1/0/0", z_rsp_valid, z_req_ready, z_rsp_err);
        end
        z_req_write = 1'b0;
        @(posedge clk);
        #1;
        total++; if (z_rsp_valid !== 1'b0 || z_req_ready !== 1'b1) begin
            bad++; $display("FAIL zw_gap got valid=%0b ready=%0b want 0/1", z_rsp_valid, z_req_ready);
        end
        @(posedge clk);
        #1;
        total++; if (z_rsp_valid !== 1'b1 || z_rsp_rdata !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL zw_b2b_load got valid=%0b rdata=%h want 1/a5a5a5a5", z_rsp_valid, z_rsp_rdata);
        end
        z_req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_first_accept();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_stall();
        test_reset_in_wait();
        test_zero_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data and address width.
REQ-002 SHALL have parameter MEM_WORDS, default 1024, meaning number of DATA_WIDTH-bit storage words.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states between request acceptance and response; legal range 0..15.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid_i, input, 1, initiator presents a request.
REQ-007 SHALL have port req_ready_o, output, 1, responder can accept a request.
REQ-008 SHALL have port req_write_i, input, 1, 1 = store, 0 = load.
REQ-009 SHALL have port req_addr_i, input, DATA_WIDTH, byte address.
REQ-010 SHALL have port req_wdata_i, input, DATA_WIDTH, store data.
REQ-011 SHALL have port req_be_i, input, DATA_WIDTH/8, store byte enables; bit n covers byte n.
REQ-012 SHALL have port rsp_valid_o, output, 1, response available.
REQ-013 SHALL have port rsp_ready_i, input, 1, initiator accepts the response.
REQ-014 SHALL have port rsp_rdata_o, output, DATA_WIDTH, load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err_o, output, 1, access error flag, valid with rsp_valid_o.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL drive req_ready_o = 1 only in IDLE; rsp_valid_o = 1 only in RESP.
REQ-018 SHALL accept a request on a rising edge where req_valid_i && req_ready_o, latching write, addr, wdata, be; request inputs are ignored in any other cycle.
REQ-019 On acceptance SHALL go IDLE->WAIT loading a counter with WAIT_CYCLES; if WAIT_CYCLES = 0, SHALL go IDLE->RESP directly.
REQ-020 In WAIT SHALL decrement the counter each cycle and go WAIT->RESP on the edge where the counter is 1.
REQ-021 SHALL perform the storage access (write commit or read capture) on the edge entering RESP; rsp_valid_o rises exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-022 In RESP SHALL hold rsp_valid_o, rsp_rdata_o, rsp_err_o stable until an edge with rsp_ready_i = 1, then go RESP->IDLE.
REQ-023 SHALL NOT accept a new request in the same cycle as the response handshake; minimum request spacing is WAIT_CYCLES+2 cycles.
REQ-024 Stores SHALL update only bytes whose req_be_i bit is 1; be = 0 SHALL be a legal no-op store with rsp_err_o = 0.
REQ-025 Loads SHALL return the full word at word index addr[..2]; req_be_i ignored for loads.
REQ-026 SHALL flag rsp_err_o = 1 when addr[1:0] != 0 or word index >= MEM_WORDS; erroring stores SHALL NOT modify storage; erroring loads return rsp_rdata_o = 0.
REQ-027 A load issued after a completed store to the same word SHALL return the stored data (no stale read).
REQ-028 Storage contents SHALL NOT be initialised by reset and are undefined until written.

Reset
REQ-029 While rst_ni = 0: state IDLE, counter 0, req_ready_o = 1, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0.
REQ-030 Reset asserted in WAIT SHALL discard the pending request (uncommitted store lost); reset asserted in RESP SHALL drop the response; already-committed stores remain.
REQ-031 First request SHALL be acceptable on the first rising edge after rst_ni deasserts.

Verification (WAIT_CYCLES = 2, MEM_WORDS = 1024)
REQ-032 Store addr 0x10, wdata 0xDEADBEEF, be 0xF, rsp_ready_i = 1 -> rsp_valid_o high 3 cycles after accept, err 0; subsequent load 0x10 -> rdata 0xDEADBEEF.
REQ-033 Store addr 0x10, wdata 0x000000AA, be 0x1 over 0xDEADBEEF -> load 0x10 returns 0xDEADBEAA.
REQ-034 Load addr 0x12 (misaligned) and load addr 0x1000 (out of range) -> rsp_err_o 1, rdata 0; store 0x1000 leaves word 0 unchanged.
REQ-035 Load with rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and rdata stable all 5 cycles, req_ready_o 0; one cycle after handshake req_ready_o 1.
REQ-036 Store to 0x20 then rst_ni pulsed low during WAIT -> outputs at reset values, FSM IDLE; load 0x20 after reset does not return the aborted store data (preload 0x11111111 first, expect 0x11111111).
REQ-037 Rebuild with WAIT_CYCLES = 0 -> rsp_valid_o high 1 cycle after accepting edge; back-to-back requests spaced exactly 2 cycles.
